accel_init_loader: RTL and testbench

Upstream loader for `accelerator_top`. It accepts a valid/ready word stream from the host side and unpacks it into sequential writes on the random write ports of `regfile_InexRecur` and `regfile_state`. It then raises `is_start` and holds it until the accelerator reports completion. It is the only writer of those ports while `is_start` is low.

---
 rtl/accel_pkg.sv | 32 +++
 rtl/accel_loader_fsm.sv | 202 ++++++++++++++++++++
 rtl/accel_init_loader.sv | 114 +++++++++++
 tb/tb_accel_init_loader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared types and constants for the accelerator init loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package accel_pkg;

   localparam int ACC_AW      = 12;
   localparam int ACC_DEPTH   = 4096;
   localparam int ST_W        = 18;
   localparam int IR_W        = 32;

   // Record-count field inside the header word.
   localparam int HDR_CNT_MSB = 12;
   localparam int HDR_CNT_LSB = 0;
   localparam int HDR_CNT_W   = HDR_CNT_MSB - HDR_CNT_LSB + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_IR = 3'd1,
      S_LOAD_ST = 3'd2,
      S_CHECK   = 3'd3,
      S_ARM     = 3'd4,
      S_RUN     = 3'd5,
      S_DRAIN   = 3'd6
   } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/accel_loader_fsm.sv
// ============================================================================
//  Module      : accel_loader_fsm
//  Description : Frame parser for the init loader. Owns the state register,
//                the address counter, the remaining-record counter and the
//                running checksum. Emits single-cycle write requests that the
//                top level registers onto the regfile ports.
//  Config      : ACCEL_LOADER_CHECKSUM_EN enables the trailer checksum word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module accel_loader_fsm
   import accel_pkg::*;
#(
   parameter int DEPTH = ACC_DEPTH,
   parameter int AW    = ACC_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   input  logic [IR_W-1:0] i_data,
   input  logic            i_last,
   input  logic            i_acc_done,
   output logic            o_ready,
   output loader_state_e   o_state,
   output logic            o_ir_wr,
   output logic            o_st_wr,
   output logic [AW-1:0]   o_addr,
   output logic            o_err_set,
   output logic            o_err_clr
);

   localparam logic [AW:0] c_rem_one = (AW+1)'(1);

   loader_state_e          r_state;
   loader_state_e          w_state_n;
   logic [AW-1:0]          r_cnt;
   logic [AW-1:0]          w_cnt_n;
   logic [AW:0]            r_rem;
   logic [AW:0]            w_rem_n;
   logic                   w_accept;
   logic [HDR_CNT_W-1:0]   w_hdr_n;
   logic                   w_hdr_ok;
   logic                   w_final_rec;

`ifdef ACCEL_LOADER_CHECKSUM_EN
   logic [IR_W-1:0]        r_csum;
   logic [IR_W-1:0]        w_csum_n;
   logic [IR_W-1:0]        w_st_ext;
   assign w_st_ext = {{(IR_W-ST_W){1'b0}}, i_data[ST_W-1:0]};
`else
   // Without the checksum only the header count field is inspected here.
   logic                   w_unused_hi;
   assign w_unused_hi = ^i_data[IR_W-1:HDR_CNT_W];
`endif

   // The stream is stalled only while a run is being armed or executed.
   assign o_ready     = (r_state != S_ARM) && (r_state != S_RUN);
   assign w_accept    = i_valid && o_ready;
   assign w_hdr_n     = i_data[HDR_CNT_MSB:HDR_CNT_LSB];
   assign w_hdr_ok    = (w_hdr_n != '0) && (32'(w_hdr_n) <= 32'(DEPTH));
   assign w_final_rec = (r_rem == c_rem_one);
   assign o_state     = r_state;
   assign o_addr      = r_cnt;

   // State, counter and checksum registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
         r_csum  <= '0;
`endif
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_rem   <= w_rem_n;
`ifdef ACCEL_LOADER_CHECKSUM_EN
         r_csum  <= w_csum_n;
`endif
      end
   end

   // Next-state, counter updates and write/error requests.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_rem_n   = r_rem;
      o_ir_wr   = 1'b0;
      o_st_wr   = 1'b0;
      o_err_set = 1'b0;
      o_err_clr = 1'b0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
      w_csum_n  = r_csum;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_n  = '0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
               w_csum_n = '0;
`endif
               if (!w_hdr_ok) begin
                  o_err_set = 1'b1;
                  w_state_n = i_last ? S_IDLE : S_DRAIN;
               end else if (i_last) begin
                  // A valid header cannot also be the final word.
                  o_err_set = 1'b1;
               end else begin
                  o_err_clr = 1'b1;
                  w_rem_n   = (AW+1)'(w_hdr_n);
                  w_state_n = S_LOAD_IR;
               end
            end
         end
         S_LOAD_IR: begin
            if (w_accept) begin
               if (i_last) begin
                  o_err_set = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  o_ir_wr   = 1'b1;
`ifdef ACCEL_LOADER_CHECKSUM_EN
                  w_csum_n  = r_csum ^ i_data;
`endif
                  w_state_n = S_LOAD_ST;
               end
            end
         end
         S_LOAD_ST: begin
            if (w_accept) begin
`ifdef ACCEL_LOADER_CHECKSUM_EN
               if (i_last) begin
                  o_err_set = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  o_st_wr  = 1'b1;
                  w_csum_n = r_csum ^ w_st_ext;
                  if (w_final_rec) begin
                     w_state_n = S_CHECK;
                  end else begin
                     w_cnt_n   = r_cnt + 1'b1;
                     w_rem_n   = r_rem - 1'b1;
                     w_state_n = S_LOAD_IR;
                  end
               end
`else
               if (w_final_rec) begin
                  // The final record is written even if in_last is missing.
                  o_st_wr   = 1'b1;
                  o_err_set = !i_last;
                  w_state_n = i_last ? S_ARM : S_DRAIN;
               end else if (i_last) begin
                  o_err_set = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  o_st_wr   = 1'b1;
                  w_cnt_n   = r_cnt + 1'b1;
                  w_rem_n   = r_rem - 1'b1;
                  w_state_n = S_LOAD_IR;
               end
`endif
            end
         end
`ifdef ACCEL_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) begin
               if (!i_last) begin
                  o_err_set = 1'b1;
                  w_state_n = S_DRAIN;
               end else if (i_data == r_csum) begin
                  w_state_n = S_ARM;
               end else begin
                  o_err_set = 1'b1;
                  w_state_n = S_IDLE;
               end
            end
         end
`endif
         S_ARM: begin
            w_state_n = S_RUN;
         end
         S_RUN: begin
            if (i_acc_done) begin
               w_state_n = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (w_accept && i_last) begin
               w_state_n = S_IDLE;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/accel_init_loader.sv
// ============================================================================
//  Module      : accel_init_loader
//  Description : Upstream loader for accelerator_top. Unpacks a valid/ready
//                word stream into sequential InexRecur/state regfile writes,
//                then requests a run and holds is_start until done.
//  Config      : ACCEL_LOADER_CHECKSUM_EN adds a trailer XOR checksum word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module accel_init_loader
   import accel_pkg::*;
#(
   parameter int DEPTH = ACC_DEPTH,
   parameter int AW    = ACC_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IR_W-1:0] in_data,
   input  logic            in_last,
   input  logic            acc_done_i,
   output logic            ir_we_o,
   output logic [AW-1:0]   ir_addr_o,
   output logic [IR_W-1:0] ir_data_o,
   output logic            st_we_o,
   output logic [AW-1:0]   st_addr_o,
   output logic [ST_W-1:0] st_data_o,
   output logic            is_start_o,
   output logic            busy_o,
   output logic            err_o
);

   loader_state_e   w_state;
   logic            w_ir_wr;
   logic            w_st_wr;
   logic [AW-1:0]   w_addr;
   logic            w_err_set;
   logic            w_err_clr;

   logic            r_ir_we;
   logic [AW-1:0]   r_ir_addr;
   logic [IR_W-1:0] r_ir_data;
   logic            r_st_we;
   logic [AW-1:0]   r_st_addr;
   logic [ST_W-1:0] r_st_data;
   logic            r_is_start;
   logic            r_err;

   accel_loader_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (in_valid),
      .i_data     (in_data),
      .i_last     (in_last),
      .i_acc_done (acc_done_i),
      .o_ready    (in_ready),
      .o_state    (w_state),
      .o_ir_wr    (w_ir_wr),
      .o_st_wr    (w_st_wr),
      .o_addr     (w_addr),
      .o_err_set  (w_err_set),
      .o_err_clr  (w_err_clr)
   );

   // Registered write ports, run request and sticky error. is_start follows
   // RUN one cycle late so it never overlaps the final state-port write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir_we    <= 1'b0;
         r_ir_addr  <= '0;
         r_ir_data  <= '0;
         r_st_we    <= 1'b0;
         r_st_addr  <= '0;
         r_st_data  <= '0;
         r_is_start <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ir_we    <= w_ir_wr;
         r_st_we    <= w_st_wr;
         if (w_ir_wr) begin
            r_ir_addr <= w_addr;
            r_ir_data <= in_data;
         end
         if (w_st_wr) begin
            r_st_addr <= w_addr;
            r_st_data <= in_data[ST_W-1:0];
         end
         r_is_start <= (w_state == S_RUN) && !acc_done_i;
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (w_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign ir_we_o    = r_ir_we;
   assign ir_addr_o  = r_ir_addr;
   assign ir_data_o  = r_ir_data;
   assign st_we_o    = r_st_we;
   assign st_addr_o  = r_st_addr;
   assign st_data_o  = r_st_data;
   assign is_start_o = r_is_start;
   assign err_o      = r_err;
   assign busy_o     = (w_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_accel_init_loader.sv
// ============================================================================
//  Module      : tb_accel_init_loader
//  Description : Self-checking bench for accel_init_loader. Expected regfile
//                writes are queued as words are driven and compared as the
//                write strobes appear.
//  Config      : ACCEL_LOADER_CHECKSUM_EN selects the trailer-word frames.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_accel_init_loader;
   import accel_pkg::*;

`ifdef ACCEL_LOADER_CHECKSUM_EN
   localparam int c_trailer = 1;
`else
   localparam int c_trailer = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        acc_done_i;
   logic        ir_we_o;
   logic [11:0] ir_addr_o;
   logic [31:0] ir_data_o;
   logic        st_we_o;
   logic [11:0] st_addr_o;
   logic [17:0] st_data_o;
   logic        is_start_o;
   logic        busy_o;
   logic        err_o;

   typedef struct packed {
      logic        is_st;
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         q[$];
   wr_t         mon_e;
   int          n_tests   = 0;
   int          n_fail    = 0;
   int          n_strobes = 0;
   int          cyc       = 0;
   int          acc_cyc   = 0;
   int          exp_addr  = 0;
   int          first_cyc;
   int          s0;
   logic [31:0] exp_xor;
   logic [11:0] last_st_addr = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   accel_init_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .acc_done_i (acc_done_i),
      .ir_we_o    (ir_we_o),
      .ir_addr_o  (ir_addr_o),
      .ir_data_o  (ir_data_o),
      .st_we_o    (st_we_o),
      .st_addr_o  (st_addr_o),
      .st_data_o  (st_data_o),
      .is_start_o (is_start_o),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (ir_we_o) begin
         n_strobes++;
         chk("ir_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("ir_order", 32'(mon_e.is_st), 32'd0);
            chk("ir_addr", 32'(ir_addr_o), 32'(mon_e.addr));
            chk("ir_data", ir_data_o, mon_e.data);
         end
      end
      if (st_we_o) begin
         n_strobes++;
         last_st_addr = st_addr_o;
         chk("start_with_st_we", 32'(is_start_o), 32'd0);
         chk("st_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("st_order", 32'(mon_e.is_st), 32'd1);
            chk("st_addr", 32'(st_addr_o), 32'(mon_e.addr));
            chk("st_data", 32'(st_data_o), mon_e.data);
         end
      end
   end

   // Drive one word and hold it until accepted; returns 1 time unit after
   // the accepting edge so the next word can follow back-to-back.
   task automatic send(input logic [31:0] d, input logic l);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 20) begin
         chk("send_timeout", 32'(guard), 32'd0);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
   endtask

   task automatic start_frame(input int n);
      send({19'h7FFFF, 13'(n)}, 1'b0);
      exp_addr = 0;
      exp_xor  = '0;
   endtask

   task automatic send_rec(input logic [31:0] ir, input logic [17:0] st, input logic final_rec);
      q.push_back('{is_st: 1'b0, addr: 12'(exp_addr), data: ir});
      exp_xor ^= ir;
      send(ir, 1'b0);
      q.push_back('{is_st: 1'b1, addr: 12'(exp_addr), data: {14'd0, st}});
      exp_xor ^= {14'd0, st};
`ifdef ACCEL_LOADER_CHECKSUM_EN
      send({14'h2AAA, st}, 1'b0);
`else
      send({14'h2AAA, st}, final_rec);
`endif
      exp_addr++;
   endtask

   task automatic finish_frame();
`ifdef ACCEL_LOADER_CHECKSUM_EN
      send(exp_xor, 1'b1);
`endif
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Expect is_start two cycles after the final accept, then end the run.
   task automatic run_and_done(input string tag);
      @(negedge clk);
      chk({tag, "_start_c1"}, 32'(is_start_o), 32'd0);
      @(negedge clk);
      chk({tag, "_start_c2"}, 32'(is_start_o), 32'd0);
      @(negedge clk);
      chk({tag, "_start_c3"}, 32'(is_start_o), 32'd1);
      chk({tag, "_ready_run"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_run"}, 32'(busy_o), 32'd1);
      @(posedge clk);
      #1 acc_done_i = 1'b1;
      @(posedge clk);
      #1 acc_done_i = 1'b0;
      @(negedge clk);
      chk({tag, "_start_fall"}, 32'(is_start_o), 32'd0);
      chk({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
      chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      acc_done_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_ir_we", 32'(ir_we_o), 32'd0);
      chk("rst_st_we", 32'(st_we_o), 32'd0);
      chk("rst_start", 32'(is_start_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_ir_data", ir_data_o, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic two-record frame.
      start_frame(2);
      send_rec(32'h11111111, 18'h00003, 1'b0);
      send_rec(32'h22222222, 18'h3FFFF, 1'b1);
      finish_frame();
      run_and_done("n2");
      chk("n2_err", 32'(err_o), 32'd0);

      // Header N=0 carrying in_last.
      s0 = n_strobes;
      send({19'h7FFFF, 13'h0}, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("n0_err", 32'(err_o), 32'd1);
      chk("n0_ready", 32'(in_ready), 32'd1);
      chk("n0_busy", 32'(busy_o), 32'd0);
      repeat (2) @(negedge clk);
      chk("n0_strobes", 32'(n_strobes - s0), 32'd0);

      // Header N=3 terminated early by in_last on the 4th word.
      s0 = n_strobes;
      start_frame(3);
      chk("early_err_clr", 32'(err_o), 32'd0);
      send_rec(32'hCAFE0001, 18'h12345, 1'b0);
      send(32'hCAFE0002, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (4) @(negedge clk);
      chk("early_strobes", 32'(n_strobes - s0), 32'd2);
      chk("early_err", 32'(err_o), 32'd1);
      chk("early_start", 32'(is_start_o), 32'd0);
      chk("early_busy", 32'(busy_o), 32'd0);

      // Header N=DEPTH+1: drain to in_last without any write.
      s0 = n_strobes;
      send({19'h0, 13'h1001}, 1'b0);
      send(32'h0BADBAD0, 1'b0);
      send(32'h0BADBAD1, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("big_err", 32'(err_o), 32'd1);
      chk("big_busy", 32'(busy_o), 32'd0);
      chk("big_strobes", 32'(n_strobes - s0), 32'd0);

      // Full-depth frame streamed with in_valid held high.
      s0 = n_strobes;
      start_frame(4096);
      first_cyc = acc_cyc;
      for (int i = 0; i < 4096; i++) begin
         send_rec($urandom, 18'($urandom), i == 4095);
      end
      finish_frame();
      chk("full_cycles", 32'(acc_cyc - first_cyc), 32'(2 * 4096 + c_trailer));
      run_and_done("full");
      chk("full_strobes", 32'(n_strobes - s0), 32'd8192);
      chk("full_last_addr", 32'(last_st_addr), 32'hFFF);

`ifdef ACCEL_LOADER_CHECKSUM_EN
      // Matching trailer starts the run.
      start_frame(1);
      send_rec(32'hA5A5A5A5, 18'h0F0F0, 1'b1);
      send(32'hA5A55555, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      run_and_done("cs_ok");
      chk("cs_ok_err", 32'(err_o), 32'd0);
      // Wrong trailer blocks the run.
      start_frame(1);
      send_rec(32'hA5A5A5A5, 18'h0F0F0, 1'b1);
      send(32'h0, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (4) @(negedge clk);
      chk("cs_bad_err", 32'(err_o), 32'd1);
      chk("cs_bad_start", 32'(is_start_o), 32'd0);
      chk("cs_bad_busy", 32'(busy_o), 32'd0);
`endif

      // Reset while waiting for the ST word; the ST accept is dropped.
      start_frame(2);
      q.push_back('{is_st: 1'b0, addr: 12'd0, data: 32'h5A5A0000});
      send(32'h5A5A0000, 1'b0);
      in_data = 32'h00001111;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_ir_we", 32'(ir_we_o), 32'd0);
      chk("rst_mid_st_we", 32'(st_we_o), 32'd0);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      chk("rst_mid_err", 32'(err_o), 32'd0);
      start_frame(1);
      send_rec(32'h77777777, 18'h2BEEF, 1'b1);
      finish_frame();
      run_and_done("after_rst");

      // acc_done outside RUN has no effect.
      @(posedge clk);
      #1 acc_done_i = 1'b1;
      @(posedge clk);
      #1 acc_done_i = 1'b0;
      @(negedge clk);
      chk("stray_done_busy", 32'(busy_o), 32'd0);
      chk("stray_done_ready", 32'(in_ready), 32'd1);

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
